// File: rtl/router_fifo_pkt.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | router_fifo_pkt : packet-aware router output FIFO with fill/status      |
// | Revision 1.0                                                            |
// +------------------------------------------------------------------------+
module router_fifo_pkt #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_MARGIN  = 2
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      soft_reset,
  input  logic                      write_enb,
  input  logic                      read_enb,
  input  logic                      lfd_state,
  input  logic [DATA_WIDTH-1:0]     data_in,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic                      pkt_active,
  output logic                      pkt_done,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = DATA_WIDTH - 1;
  localparam int LW       = DATA_WIDTH - 2;
  localparam int AF_LEVEL = DEPTH - AF_MARGIN;
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] REM_ONE  = CW'(1);

  logic [DATA_WIDTH:0] mem [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic [CW-1:0]         rem_cnt_q, rem_cnt_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  pkt_done_q, pkt_done_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH:0]   rd_word;
  logic [LW-1:0]         pkt_len;

  assign full        = (cnt_q == FULL_LVL);
  assign empty       = (cnt_q == '0);
  assign almost_full = (int'(cnt_q) >= AF_LEVEL);
  assign fill_level  = cnt_q;
  assign pkt_active  = (rem_cnt_q != '0);
  assign pkt_done    = pkt_done_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign data_out    = data_out_q;

  assign wr_acc  = write_enb && !full && !soft_reset;
  assign rd_acc  = read_enb && !empty && !soft_reset;
  assign rd_word = mem[rd_ptr_q];
  assign pkt_len = rd_word[DATA_WIDTH-1:2];

  // Memory is never cleared by either reset; only the pointers are.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= {lfd_state, data_in};
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    rem_cnt_d   = rem_cnt_q;
    data_out_d  = data_out_q;
    pkt_done_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (soft_reset) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      rem_cnt_d   = '0;
      data_out_d  = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (write_enb && full) overflow_d  = 1'b1;
      if (read_enb && empty) underflow_d = 1'b1;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;

      case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase

      if (rd_acc) begin
        data_out_d = rd_word[DATA_WIDTH-1:0];
        // Header reload counts payload plus the trailing parity byte.
        if (rd_word[DATA_WIDTH]) begin
          rem_cnt_d = CW'(pkt_len) + REM_ONE;
        end else if (rem_cnt_q != '0) begin
          rem_cnt_d  = rem_cnt_q - REM_ONE;
          pkt_done_d = (rem_cnt_q == REM_ONE);
        end
      end else if (rem_cnt_q == '0) begin
        data_out_d = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rem_cnt_q   <= '0;
      data_out_q  <= '0;
      pkt_done_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rem_cnt_q   <= rem_cnt_d;
      data_out_q  <= data_out_d;
      pkt_done_q  <= pkt_done_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_router_fifo_pkt.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_router_fifo_pkt : scoreboard bench for router_fifo_pkt (8/16/2)      |
// | Revision 1.0                                                            |
// +------------------------------------------------------------------------+
module tb_router_fifo_pkt;

  logic       clock;
  logic       resetn;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [4:0] fill_level;
  logic       pkt_active;
  logic       pkt_done;
  logic       overflow;
  logic       underflow;

  typedef struct {
    logic [7:0] d;
    logic       act;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  logic rd_exp;
  int   tests;
  int   failed;

  router_fifo_pkt #(.DATA_WIDTH(8), .DEPTH(16), .AF_MARGIN(2)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .soft_reset  (soft_reset),
    .write_enb   (write_enb),
    .read_enb    (read_enb),
    .lfd_state   (lfd_state),
    .data_in     (data_in),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .fill_level  (fill_level),
    .pkt_active  (pkt_active),
    .pkt_done    (pkt_done),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Read data is checked half a cycle after the edge that accepted the read.
  initial begin
    logic pend;
    exp_t e;
    forever begin
      @(posedge clock);
      pend = rd_exp;
      @(negedge clock);
      if (pend) begin
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL rd_data: read observed with empty scoreboard, data_out=%0h", data_out);
        end else begin
          e = exp_q.pop_front();
          if (data_out !== e.d || pkt_active !== e.act || pkt_done !== e.done) begin
            failed++;
            $display("FAIL rd_data: got d=%0h act=%0b done=%0b, required d=%0h act=%0b done=%0b",
                     data_out, pkt_active, pkt_done, e.d, e.act, e.done);
          end
        end
      end
    end
  end

  task automatic step(input logic w, input logic r, input logic l, input logic [7:0] d,
                      input logic sr, input logic re, input logic [7:0] ed,
                      input logic ea, input logic edn);
    exp_t e;
    write_enb  = w;
    read_enb   = r;
    lfd_state  = l;
    data_in    = d;
    soft_reset = sr;
    rd_exp     = re;
    if (re) begin
      e.d = ed; e.act = ea; e.done = edn;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    write_enb = 0; read_enb = 0; lfd_state = 0; data_in = 0; soft_reset = 0; rd_exp = 0;
  endtask

  task automatic wr(input logic [7:0] d, input logic l);
    step(1, 0, l, d, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic rd(input logic [7:0] ed, input logic ea, input logic edn);
    step(0, 1, 0, 8'h00, 0, 1, ed, ea, edn);
  endtask

  task automatic sreset();
    step(0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
  endtask

  initial begin
    logic [7:0] pk [7];
    pk = '{8'h15, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h3C};
    tests = 0; failed = 0;
    resetn = 0; soft_reset = 0; write_enb = 0; read_enb = 0;
    lfd_state = 0; data_in = 0; rd_exp = 0;
    repeat (2) @(posedge clock);
    #1 resetn = 1;

    check("rst_data_out", data_out, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_afull", almost_full, 0);
    check("rst_fill", fill_level, 0);
    check("rst_active", pkt_active, 0);
    check("rst_done", pkt_done, 0);
    check("rst_oflow", overflow, 0);
    check("rst_uflow", underflow, 0);

    // Async reset with entries stored
    step(0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    check("uflow_first", underflow, 1);
    check("uflow_fill", fill_level, 0);
    wr(8'h11, 0); wr(8'h22, 0); wr(8'h33, 0);
    check("fill3", fill_level, 3);
    check("fill3_empty", empty, 0);
    #3 resetn = 0;
    #1;
    check("arst_fill", fill_level, 0);
    check("arst_empty", empty, 1);
    check("arst_uflow", underflow, 0);
    check("arst_data", data_out, 0);
    check("arst_active", pkt_active, 0);
    @(posedge clock);
    #1 resetn = 1;

    // Fill, almost-full, overflow, drain, underflow
    sreset();
    for (int i = 0; i < 16; i++) begin
      wr(8'h40 + 8'(i), 0);
      check("fill_level", fill_level, i + 1);
      check("afull", almost_full, (i + 1 >= 14) ? 1 : 0);
      check("full", full, (i + 1 == 16) ? 1 : 0);
    end
    check("oflow_before", overflow, 0);
    wr(8'hFF, 0);
    check("oflow_set", overflow, 1);
    check("oflow_fill", fill_level, 16);
    for (int i = 0; i < 16; i++) rd(8'h40 + 8'(i), 0, 0);
    check("drain_empty", empty, 1);
    check("uflow_before", underflow, 0);
    step(0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    check("uflow_set", underflow, 1);
    check("uflow_fill", fill_level, 0);
    check("idle_data_zero", data_out, 0);

    // Packet readout
    sreset();
    for (int i = 0; i < 7; i++) wr(pk[i], (i == 0) ? 1'b1 : 1'b0);
    for (int i = 0; i < 7; i++) rd(pk[i], (i < 6) ? 1'b1 : 1'b0, (i == 6) ? 1'b1 : 1'b0);
    step(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    check("pkt_idle_data", data_out, 0);
    check("pkt_idle_done", pkt_done, 0);
    check("pkt_idle_active", pkt_active, 0);

    // Full with simultaneous read and write
    sreset();
    for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i), 0);
    check("rw_full", full, 1);
    step(1, 1, 0, 8'hEE, 0, 1, 8'h80, 0, 0);
    check("rw_oflow", overflow, 1);
    check("rw_fill", fill_level, 15);
    for (int i = 1; i < 16; i++) rd(8'h80 + 8'(i), 0, 0);
    check("rw_empty", empty, 1);

    // Pointer wrap
    sreset();
    for (int i = 0; i < 12; i++) wr(8'h10 + 8'(i), 0);
    for (int i = 0; i < 12; i++) rd(8'h10 + 8'(i), 0, 0);
    for (int i = 0; i < 12; i++) wr(8'hC0 + 8'(i), 0);
    check("wrap_fill", fill_level, 12);
    for (int i = 0; i < 12; i++) rd(8'hC0 + 8'(i), 0, 0);
    check("wrap_empty", empty, 1);

    // Soft reset mid-packet
    sreset();
    for (int i = 0; i < 7; i++) wr(pk[i], (i == 0) ? 1'b1 : 1'b0);
    rd(8'h15, 1, 0);
    rd(8'hA1, 1, 0);
    rd(8'hA2, 1, 0);
    check("sr_active_pre", pkt_active, 1);
    step(1, 0, 0, 8'h77, 1, 0, 8'h00, 0, 0);
    check("sr_fill", fill_level, 0);
    check("sr_empty", empty, 1);
    check("sr_active", pkt_active, 0);
    check("sr_data", data_out, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/router_fifo_pkt.md
# router_fifo_pkt

Parametrised, packet-aware synchronous FIFO for the router output path. It generalises the 16x9 router FIFO to configurable data width and depth, and stores a header flag per entry. It tracks the remaining length of the packet currently being read out, and adds fill level, almost-full, sticky overflow/underflow flags and a packet-complete pulse. One instance sits between the router synchroniser/FSM and each output port.

## Interface
- DATA_WIDTH, 8, data bits per entry (>= 3); header format is {payload_length[DATA_WIDTH-1:2], addr[1:0]}
- DEPTH, 16, entries; power of two, >= 4; AW = log2(DEPTH)
- AF_MARGIN, 2, almost_full asserts when fill_level >= DEPTH - AF_MARGIN
- clock  in  1  single clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- soft_reset  in  1  synchronous flush, active-high
- write_enb  in  1  write request
- read_enb  in  1  read request
- lfd_state  in  1  marks data_in as a packet header; stored with the entry
- data_in  in  DATA_WIDTH  write data
- data_out  out  DATA_WIDTH  registered read data
- full  out  1  fill_level == DEPTH
- empty  out  1  fill_level == 0
- almost_full  out  1  see AF_MARGIN
- fill_level  out  AW+1  entries stored
- pkt_active  out  1  remaining-count of current read packet non-zero
- pkt_done  out  1  one-cycle pulse on the read that drains the last byte (parity) of a packet
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH x (DATA_WIDTH+1); bit DATA_WIDTH = lfd_state at write time.
- Write accepted when write_enb && !full: mem[wr_ptr] <= {lfd_state, data_in}; wr_ptr+1.
- Read accepted when read_enb && !empty: data_out <= mem[rd_ptr][DATA_WIDTH-1:0]; rd_ptr+1.
- Full blocks writes even when a read is accepted in the same cycle; the read still proceeds.
- Simultaneous accepted read and write: fill_level unchanged.
- Pointers are AW bits and wrap modulo DEPTH; FIFO order is preserved across wrap.
- Rejected write sets overflow; rejected read sets underflow; no state changes otherwise.
- Packet counter rem_cnt, DATA_WIDTH-1 bits:
  - accepted read of a header entry: rem_cnt <= payload_length + 1 (payload + parity); reloads even if rem_cnt != 0 (no pkt_done).
  - accepted read of a non-header entry with rem_cnt != 0: rem_cnt - 1; pkt_done pulses when this takes it 1 -> 0.
  - non-header read with rem_cnt == 0: data output normally, counter unchanged.
- Any clock edge with no accepted read and rem_cnt == 0: data_out <= 0. With rem_cnt != 0, data_out holds its value.
- pkt_active = (rem_cnt != 0).
- soft_reset (priority over read/write in the same cycle): pointers, fill_level, rem_cnt, data_out, overflow and underflow go to 0; memory contents are not cleared.
- resetn low: same clear as soft_reset, applied asynchronously; it is released on the next rising edge.

## Timing
- Reset values: data_out 0, full 0, empty 1, almost_full 0 (1 only if AF_MARGIN >= DEPTH), fill_level 0, pkt_active 0, pkt_done 0, overflow 0, underflow 0.
- Status outputs are decoded combinationally from the registered fill counter and rem_cnt, so they change after the edge that accepts the operation.
- Read latency is one cycle: data_out is valid in the cycle after read_enb is sampled with !empty.
- No write-to-read bypass: a word written at edge N is readable at edge N+1 at the earliest.
- pkt_done is high for exactly the cycle following the draining read edge, aligned with the parity byte on data_out.

## Test plan
- Reset: assert resetn=0 mid-cycle with 3 entries stored -> all outputs take their reset values immediately; empty=1, fill_level=0.
- Fill/overflow (8/16/2): 16 writes -> full=1, almost_full from fill 14. 17th write -> overflow=1, fill_level stays 16. Read on empty after draining -> underflow=1.
- Packet: write header 0x15 (len 5, addr 01) with lfd_state=1, payloads 0xA1..0xA5, parity 0x3C; read 7 consecutive -> data_out 0x15, A1..A5, 3C; pkt_active=1 for 6 cycles; pkt_done on the 3C cycle; data_out=0 on the next idle cycle.
- Full with read+write: at fill 16, read_enb=write_enb=1 -> the read is returned, the write is rejected (overflow=1), fill_level=15.
- Wrap: write 12, read 12, write 12 distinct values, read 12 -> exact order, empty=1 at end.
- soft_reset mid-packet: after header and 2 payload reads (rem_cnt=4), pulse soft_reset with write_enb=1 -> fill_level=0, pkt_active=0, data_out=0, write ignored.
